u111_bus_sizer: RTL

- Generalised 68040 local-bus data-transfer and dynamic bus-sizing engine for U111.
- Splits one CPU transfer (byte, word, long, line) into 1–4 local cycles sized to the addressed port: 32-, 16- or 8-bit.
- Steers and assembles byte lanes, handles retry, retry limit and a termination watchdog, then returns a single termination to the CPU.
- Sits between the CPU-side decode and the Amiga-side local bus; the data path uses split in/out buses, and the top level owns the tristates.

---
 rtl/u111_bus_sizer.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/u111_bus_sizer.sv
// rtl/u111_bus_sizer.sv - 68040 local-bus dynamic bus sizer for U111
// Splits one CPU transfer into port-sized local cycles and returns a single CPU termination.
module u111_bus_sizer #(
   parameter int RETRY_LIMIT    = 3,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int LINE_SPLIT     = 1
) (
   input  logic        CLK40,
   input  logic        RESETn,
   input  logic        TS_CPUn,
   input  logic        RnW,
   input  logic [1:0]  SIZ,
   input  logic [1:0]  A_CPU,
   input  logic [1:0]  PORTSIZE,
   input  logic [31:0] D_CPU_WR,
   output logic [31:0] D_CPU_RD,
   output logic        TA_CPUn,
   output logic        TEA_CPUn,
   output logic        TBI_CPUn,
   output logic        TSn,
   output logic [1:0]  A_LOC,
   output logic [1:0]  SIZ_LOC,
   output logic [31:0] D_LOC_WR,
   input  logic [31:0] D_LOC_RD,
   input  logic        TACKn,
   input  logic        TEAn,
   output logic        BUSY
);

   typedef enum logic [2:0] {S_IDLE, S_SIZE, S_START, S_WAIT, S_TERM, S_ERR} state_t;

   localparam logic [3:0] RETRY_MAX = 4'(RETRY_LIMIT);
   localparam logic [9:0] WD_LAST   = 10'(TIMEOUT_CYCLES - 1);

   state_t      state;
   logic        rnw_q;
   logic        tbi_pend;
   logic [1:0]  siz_q;
   logic [1:0]  a_q;
   logic [1:0]  k;
   logic [1:0]  k_last;
   logic [1:0]  pw_sh;
   logic [1:0]  m_sh;
   logic [31:0] wdata_q;
   logic [31:0] rd_latch;
   logic [3:0]  retry_cnt;
   logic [9:0]  wd_cnt;

   logic [1:0]  port_sh;
   logic [1:0]  xfer_sh;
   logic [1:0]  k_off;
   logic [1:0]  a_cur;
   logic [1:0]  rel;
   logic [1:0]  lane;
   logic [2:0]  m_bytes;
   logic [31:0] wr_steer;
   logic [31:0] rd_merge;

   // Widths held as log2 of the byte count; the reserved port code behaves as 32-bit.
   always_comb begin
      case (PORTSIZE)
         2'b01:   port_sh = 2'd1;
         2'b10:   port_sh = 2'd0;
         default: port_sh = 2'd2;
      endcase
      case (siz_q)
         2'b01:   xfer_sh = 2'd0;
         2'b10:   xfer_sh = 2'd1;
         default: xfer_sh = 2'd2;
      endcase
   end

   // Byte lanes covered by the current sub-cycle, big-endian, port data left-justified.
   always_comb begin
      case (pw_sh)
         2'd1:    k_off = {k[0], 1'b0};
         2'd0:    k_off = k;
         default: k_off = 2'd0;
      endcase
      a_cur    = a_q + k_off;
      m_bytes  = 3'd1 << m_sh;
      wr_steer = '0;
      rd_merge = rd_latch;
      rel      = '0;
      lane     = '0;
      for (int o = 0; o < 4; o++) begin
         rel  = 2'(o) - a_cur;
         lane = (pw_sh == 2'd1) ? {1'b0, 1'(o)} : 2'd0;
         if ({1'b0, rel} < m_bytes) begin
            wr_steer[8*(3-lane) +: 8] = wdata_q[8*(3-o) +: 8];
            rd_merge[8*(3-o) +: 8]    = D_LOC_RD[8*(3-lane) +: 8];
         end
      end
      if (pw_sh == 2'd2) begin
         wr_steer = wdata_q;
         rd_merge = D_LOC_RD;
      end
   end

   always_ff @(posedge CLK40 or negedge RESETn) begin
      if (!RESETn) begin
         state     <= S_IDLE;
         TSn       <= 1'b1;
         TA_CPUn   <= 1'b1;
         TEA_CPUn  <= 1'b1;
         TBI_CPUn  <= 1'b1;
         BUSY      <= 1'b0;
         A_LOC     <= 2'b00;
         SIZ_LOC   <= 2'b00;
         D_CPU_RD  <= '0;
         D_LOC_WR  <= '0;
         rnw_q     <= 1'b0;
         tbi_pend  <= 1'b0;
         siz_q     <= 2'b00;
         a_q       <= 2'b00;
         k         <= 2'd0;
         k_last    <= 2'd0;
         pw_sh     <= 2'd0;
         m_sh      <= 2'd0;
         wdata_q   <= '0;
         rd_latch  <= '0;
         retry_cnt <= '0;
         wd_cnt    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               TA_CPUn  <= 1'b1;
               TEA_CPUn <= 1'b1;
               TBI_CPUn <= 1'b1;
               if (BUSY) begin
                  BUSY <= 1'b0;
               end else if (!TS_CPUn) begin
                  rnw_q     <= RnW;
                  siz_q     <= SIZ;
                  a_q       <= A_CPU;
                  wdata_q   <= D_CPU_WR;
                  rd_latch  <= '0;
                  k         <= 2'd0;
                  retry_cnt <= '0;
                  tbi_pend  <= 1'b0;
                  BUSY      <= 1'b1;
                  state     <= S_SIZE;
               end
            end
            S_SIZE: begin
               pw_sh  <= port_sh;
               m_sh   <= (xfer_sh < port_sh) ? xfer_sh : port_sh;
               k_last <= (xfer_sh > port_sh) ? (2'd1 << (xfer_sh - port_sh)) - 2'd1 : 2'd0;
               state  <= S_START;
               if (siz_q == 2'b11 && port_sh != 2'd2) begin
                  if (LINE_SPLIT != 0) tbi_pend <= 1'b1;
                  else                 state    <= S_ERR;
               end
            end
            S_START: begin
               TSn      <= 1'b0;
               A_LOC    <= a_cur;
               D_LOC_WR <= wr_steer;
               wd_cnt   <= '0;
               case (m_sh)
                  2'd0:    SIZ_LOC <= 2'b01;
                  2'd1:    SIZ_LOC <= 2'b10;
                  default: SIZ_LOC <= 2'b00;
               endcase
               state <= S_WAIT;
            end
            S_WAIT: begin
               TSn <= 1'b1;
               case ({TACKn, TEAn})
                  2'b01: begin
                     if (rnw_q) rd_latch <= rd_merge;
                     retry_cnt <= '0;
                     if (k == k_last) begin
                        state <= S_TERM;
                     end else begin
                        k     <= k + 2'd1;
                        state <= S_START;
                     end
                  end
                  2'b00: begin
                     if (retry_cnt == RETRY_MAX) begin
                        state <= S_ERR;
                     end else begin
                        retry_cnt <= retry_cnt + 4'd1;
                        state     <= S_START;
                     end
                  end
                  2'b10:   state <= S_ERR;
                  default: begin
                     if (wd_cnt == WD_LAST) state  <= S_ERR;
                     else                   wd_cnt <= wd_cnt + 10'd1;
                  end
               endcase
            end
            S_TERM: begin
               TA_CPUn  <= 1'b0;
               TBI_CPUn <= ~tbi_pend;
               D_CPU_RD <= rd_latch;
               state    <= S_IDLE;
            end
            S_ERR: begin
               TEA_CPUn <= 1'b0;
               D_CPU_RD <= '0;
               state    <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
